// File: rtl/midi_transmitter_pkg.sv
// midi_transmitter_pkg: MIDI message types, constants and byte-forming helper.
package midi_transmitter_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int MIDI_BAUD = 31250;
  typedef enum logic [3:0] {NOTE_OFF = 4'h8, NOTE_ON = 4'h9} status_t;
  typedef struct packed {
    status_t status;
    logic [DATA_WIDTH-1:0] note_number;
    logic [DATA_WIDTH-1:0] velocity;
  } note_change_t;
  // Byte idx of a note message: 0 status, 1 note number, 2+ velocity; data bytes keep bit 7 clear.
  function automatic logic [DATA_WIDTH-1:0] msg_byte(input note_change_t n, input logic [1:0] idx, input logic [3:0] ch);
    return idx == 2'd0 ? {n.status, ch} : idx == 2'd1 ? n.note_number & 8'h7f : n.velocity & 8'h7f;
  endfunction
endpackage

// File: rtl/midi_transmitter_if.sv
// midi_transmitter_if: note handshake between a note source and the transmitter.
interface midi_transmitter_if;
  import midi_transmitter_pkg::*;
  note_change_t note;
  logic note_valid;
  logic note_ready;
  modport master(output note, note_valid, input note_ready);
  modport slave(input note, note_valid, output note_ready);
endinterface

// File: rtl/midi_transmitter_uart_tx.sv
// uart_tx: 8N1 byte serializer; ready pulses on the last stop-bit cycle so bytes chain without gaps.
module uart_tx #(
  parameter int DIV = 1600
) (
  input  logic       clock_50_000_000,
  input  logic       reset_l,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial
);
  localparam int CW = $clog2(DIV + 1);
  logic active, last;
  logic [9:0] shreg;
  logic [3:0] bit_cnt;
  logic [CW-1:0] cyc_cnt;
  assign last = cyc_cnt == CW'(DIV - 1);
  assign tx_ready = !active || (last && bit_cnt == 4'd9);
  assign serial = active ? shreg[0] : 1'b1;
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) begin
      active <= 1'b0;
      shreg <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (tx_valid && tx_ready) begin
      active <= 1'b1;
      shreg <= {1'b1, tx_byte, 1'b0};
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (active) begin
      cyc_cnt <= last ? '0 : cyc_cnt + 1'b1;
      if (last) begin
        shreg <= {1'b1, shreg[9:1]};
        bit_cnt <= bit_cnt == 4'd9 ? 4'd0 : bit_cnt + 4'd1;
        if (bit_cnt == 4'd9) active <= 1'b0;
      end
    end
endmodule

// File: rtl/midi_transmitter.sv
// midi_transmitter: note-on/off message sequencer with running status over a MIDI UART.
module midi_transmitter
  import midi_transmitter_pkg::*;
#(
  parameter int CLOCK_HZ = 50_000_000,
  parameter int BAUD = MIDI_BAUD,
  parameter int CHANNEL = 0,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                clock_50_000_000,
  input  logic                reset_l,
  midi_transmitter_if.slave   bus,
  output logic                midi_tx,
  output logic                busy
);
  localparam int DIV = CLOCK_HZ / BAUD;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  note_change_t hold;
  logic [1:0] byte_idx;
  logic [7:0] last_status, status_byte, u_byte;
  logic last_valid, skip, accept, u_valid, u_ready;
  assign status_byte = msg_byte(bus.note, 2'd0, 4'(CHANNEL));
  assign skip = RUNNING_STATUS != 0 && last_valid && status_byte == last_status;
  assign bus.note_ready = state == IDLE;
  assign accept = bus.note_valid && bus.note_ready;
  assign busy = !bus.note_ready;
  // The first byte is loaded straight from the port so its start bit follows acceptance.
  always_comb begin
    state_nx = state;
    u_valid = 1'b0;
    u_byte = '0;
    if (state == IDLE) begin
      u_valid = bus.note_valid;
      u_byte = msg_byte(bus.note, skip ? 2'd1 : 2'd0, 4'(CHANNEL));
      state_nx = bus.note_valid ? SEND : IDLE;
    end else begin
      u_valid = byte_idx != 2'd2;
      u_byte = msg_byte(hold, byte_idx + 2'd1, 4'(CHANNEL));
      state_nx = byte_idx == 2'd2 && u_ready ? IDLE : SEND;
    end
  end
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) begin
      state <= IDLE;
      hold <= '0;
      byte_idx <= '0;
      last_status <= '0;
      last_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        hold <= bus.note;
        byte_idx <= skip ? 2'd1 : 2'd0;
        if (!skip) begin
          last_status <= status_byte;
          last_valid <= 1'b1;
        end
      end else if (state == SEND && u_valid && u_ready) byte_idx <= byte_idx + 2'd1;
    end
  uart_tx #(.DIV(DIV)) u_uart (
    .clock_50_000_000(clock_50_000_000),
    .reset_l(reset_l),
    .tx_byte(u_byte),
    .tx_valid(u_valid),
    .tx_ready(u_ready),
    .serial(midi_tx)
  );
endmodule

// File: doc/midi_transmitter.md
MIDI_TRANSMITTER -- requirements
Module: midi_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 SHALL have parameter CHANNEL, default 0, 4-bit MIDI channel in status-byte low nibble.
REQ-004 SHALL have parameter RUNNING_STATUS, default 1, 1 = omit a status byte equal to the last one sent.
REQ-005 SHALL have port clock_50_000_000  input  1  system clock.
REQ-006 SHALL have port reset_l  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port note  input  note_change_t  status (ON/OFF), note_number, velocity.
REQ-008 SHALL have port note_valid  input  1  note is valid this cycle.
REQ-009 SHALL have port note_ready  output  1  block can accept a note this cycle.
REQ-010 SHALL have port midi_tx  output  1  MIDI UART serial out; idle high.
REQ-011 SHALL have port busy  output  1  a message is being serialized.

Function
REQ-012 SHALL accept a note only on a cycle where note_valid && note_ready; accepted fields are captured into a holding register.
REQ-013 SHALL assert note_ready only in IDLE; note_valid while busy is ignored, and the source holds it until accepted.
REQ-014 SHALL form the message as status byte, then note_number, then velocity. Status byte = 0x90|CHANNEL for ON, 0x80|CHANNEL for OFF.
REQ-015 SHALL force bit 7 of both data bytes to 0, sending only the low 7 bits of note_number and velocity.
REQ-016 SHALL serialize each byte as 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1).
REQ-017 SHALL hold each bit for exactly DIV = CLOCK_HZ/BAUD cycles (1600 at defaults) using a cycle counter that wraps at DIV-1.
REQ-018 SHALL drive the start bit of the first byte on the cycle after acceptance.
REQ-019 SHALL send the bytes of one message back-to-back, with no idle gap between a stop bit and the next start bit.
REQ-020 SHALL, when RUNNING_STATUS=1 and the new status byte equals the last transmitted status byte, skip the status byte and send 2 bytes (20 bit-times).
REQ-021 SHALL otherwise send 3 bytes (30 bit-times) and update the last-status register.
REQ-022 SHALL use sequencer states IDLE -> SEND; SEND advances byte index 0..2 (starting at 1 when status is skipped).
REQ-023 SHALL leave SEND for IDLE at the end of the last stop bit and assert note_ready on the following cycle.
REQ-024 SHALL assert busy from the acceptance cycle+1 until the cycle IDLE is re-entered; busy = !note_ready.
REQ-025 SHALL keep midi_tx high in IDLE.

Reset
REQ-026 SHALL on reset_l low, immediately and asynchronously: midi_tx=1, note_ready=1 after release, busy=0, state IDLE, all counters 0, holding register 0, last-status invalid (next message always sends status).
REQ-027 SHALL abandon a frame in progress when reset is asserted mid-frame; no partial byte resumes after release.

Structure
REQ-028 SHALL take from the MIDI package: note_change_t, status_t, DATA_WIDTH, the NOTE_ON (0x9) and NOTE_OFF (0x8) status nibbles, and the MIDI_BAUD constant.
REQ-029 SHALL use one sub-module, uart_tx: a byte serializer with byte/valid/ready in and serial out, parameterized by DIV. midi_transmitter holds the message sequencer and running-status logic.

Verification
REQ-030 Reset, then ON note 60 vel 100 -> midi_tx carries 0x90,0x3C,0x64 LSB first, each bit 1600 cycles; 48000 cycles total; note_ready returns next cycle.
REQ-031 Then ON note 64 vel 90 with RUNNING_STATUS=1 -> only 0x40,0x5A sent in 32000 cycles; with RUNNING_STATUS=0 -> 0x90,0x40,0x5A in 48000 cycles.
REQ-032 OFF note 60 vel 0, CHANNEL=3 -> 0x83,0x3C,0x00.
REQ-033 note_valid held high for a second note during a message -> second note is not accepted until note_ready rises, then starts 1 cycle later with no lost or duplicated bytes.
REQ-034 note_number=0xBC and velocity=0xFF -> data bytes 0x3C and 0x7F.
REQ-035 reset_l pulsed low mid-data-bit -> midi_tx high within the same cycle; the next ON message includes its status byte.
